// File: rtl/rs_alu_if.sv
// rs_alu_if: dispatch, common-data-bus and issue signals of the ALU
// reservation station.
//   master : dispatcher/CDB/ROB side; drives flush, in_*, cdb_*;
//            observes full and the out_* issue registers.
//   slave  : the reservation station itself.
interface rs_alu_if #(
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
);
    logic              flush;
    logic              in_valid;
    logic [OP_W-1:0]   in_op;
    logic [ROB_W-1:0]  in_rob_tag;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_imm;
    logic [ROB_W-1:0]  in_qj;
    logic [ROB_W-1:0]  in_qk;
    logic [DATA_W-1:0] in_vj;
    logic [DATA_W-1:0] in_vk;
    logic              full;
    logic [ROB_W-1:0]  cdb_alu_tag;
    logic [DATA_W-1:0] cdb_alu_data;
    logic [ROB_W-1:0]  cdb_ls_tag;
    logic [DATA_W-1:0] cdb_ls_data;
    logic [OP_W-1:0]   out_op;
    logic [ROB_W-1:0]  out_rob_tag;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [DATA_W-1:0] out_imm;

    modport master (
        output flush, in_valid, in_op, in_rob_tag, in_pc, in_imm,
               in_qj, in_qk, in_vj, in_vk,
               cdb_alu_tag, cdb_alu_data, cdb_ls_tag, cdb_ls_data,
        input  full, out_op, out_rob_tag, out_pc, out_a, out_b, out_imm
    );

    modport slave (
        input  flush, in_valid, in_op, in_rob_tag, in_pc, in_imm,
               in_qj, in_qk, in_vj, in_vk,
               cdb_alu_tag, cdb_alu_data, cdb_ls_tag, cdb_ls_data,
        output full, out_op, out_rob_tag, out_pc, out_a, out_b, out_imm
    );
endinterface

// File: rtl/rs_alu.sv
// rs_alu: reservation station in front of the integer ALU.
// Buffers dispatched micro-ops until both operands are known, snoops the
// ALU and load result buses for missing operands, and issues the
// lowest-index ready slot each cycle into registered outputs.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : rs_alu_if.slave (flush, dispatch in_*, full, cdb_*, issue out_*)
module rs_alu #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3,
    parameter int ROB_W   = 4,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 6
) (
    input  logic   clk,
    input  logic   rst_n,
    rs_alu_if.slave bus
);

    // Operand: producer tag (0 = value valid) plus value.
    typedef struct packed {
        logic [ROB_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } opnd_t;

    // Capture a pending operand from the CDBs; the ALU bus has priority.
    function automatic opnd_t wake(
        input opnd_t             o,
        input logic [ROB_W-1:0]  alu_tag,
        input logic [DATA_W-1:0] alu_data,
        input logic [ROB_W-1:0]  ls_tag,
        input logic [DATA_W-1:0] ls_data
    );
        opnd_t r;
        r = o;
        if (o.tag != '0 && o.tag == alu_tag) begin
            r.tag = '0;
            r.val = alu_data;
        end else if (o.tag != '0 && o.tag == ls_tag) begin
            r.tag = '0;
            r.val = ls_data;
        end
        return r;
    endfunction

    logic [ENTRIES-1:0] busy_q, busy_d;
    logic [OP_W-1:0]    op_q   [ENTRIES];
    logic [OP_W-1:0]    op_d   [ENTRIES];
    logic [ROB_W-1:0]   tag_q  [ENTRIES];
    logic [ROB_W-1:0]   tag_d  [ENTRIES];
    logic [DATA_W-1:0]  pc_q   [ENTRIES];
    logic [DATA_W-1:0]  pc_d   [ENTRIES];
    logic [DATA_W-1:0]  imm_q  [ENTRIES];
    logic [DATA_W-1:0]  imm_d  [ENTRIES];
    opnd_t              srcj_q [ENTRIES];
    opnd_t              srcj_d [ENTRIES];
    opnd_t              srck_q [ENTRIES];
    opnd_t              srck_d [ENTRIES];

    logic [OP_W-1:0]    out_op_q, out_op_d;
    logic [ROB_W-1:0]   out_rob_tag_q, out_rob_tag_d;
    logic [DATA_W-1:0]  out_pc_q, out_pc_d;
    logic [DATA_W-1:0]  out_a_q, out_a_d;
    logic [DATA_W-1:0]  out_b_q, out_b_d;
    logic [DATA_W-1:0]  out_imm_q, out_imm_d;

    logic               full_w;
    logic               issue_valid;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   free_idx;

    assign full_w = &busy_q;

    always_comb begin
        busy_d        = busy_q;
        op_d          = op_q;
        tag_d         = tag_q;
        pc_d          = pc_q;
        imm_d         = imm_q;
        srcj_d        = srcj_q;
        srck_d        = srck_q;
        out_op_d      = '0;
        out_rob_tag_d = '0;
        out_pc_d      = out_pc_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_imm_d     = out_imm_q;
        issue_valid   = 1'b0;
        issue_idx     = '0;
        free_idx      = '0;

        // Descending scans so the lowest index wins.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (busy_q[i] && srcj_q[i].tag == '0 && srck_q[i].tag == '0) begin
                issue_valid = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end

        for (int i = 0; i < ENTRIES; i++) begin
            if (busy_q[i] && !(issue_valid && issue_idx == IDX_W'(i))) begin
                srcj_d[i] = wake(srcj_q[i], bus.cdb_alu_tag, bus.cdb_alu_data,
                                 bus.cdb_ls_tag, bus.cdb_ls_data);
                srck_d[i] = wake(srck_q[i], bus.cdb_alu_tag, bus.cdb_alu_data,
                                 bus.cdb_ls_tag, bus.cdb_ls_data);
            end
        end

        if (issue_valid) begin
            busy_d[issue_idx] = 1'b0;
            out_op_d          = op_q[issue_idx];
            out_rob_tag_d     = tag_q[issue_idx];
            out_pc_d          = pc_q[issue_idx];
            out_a_d           = srcj_q[issue_idx].val;
            out_b_d           = srck_q[issue_idx].val;
            out_imm_d         = imm_q[issue_idx];
        end

        // The free slot is chosen from pre-edge busy bits, so it never
        // collides with the issuing slot or a waking slot.
        if (bus.in_valid && !full_w) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = bus.in_op;
            tag_d[free_idx]  = bus.in_rob_tag;
            pc_d[free_idx]   = bus.in_pc;
            imm_d[free_idx]  = bus.in_imm;
            srcj_d[free_idx] = wake(opnd_t'({bus.in_qj, bus.in_vj}),
                                    bus.cdb_alu_tag, bus.cdb_alu_data,
                                    bus.cdb_ls_tag, bus.cdb_ls_data);
            srck_d[free_idx] = wake(opnd_t'({bus.in_qk, bus.in_vk}),
                                    bus.cdb_alu_tag, bus.cdb_alu_data,
                                    bus.cdb_ls_tag, bus.cdb_ls_data);
        end

        if (bus.flush) begin
            busy_d        = '0;
            out_op_d      = '0;
            out_rob_tag_d = '0;
            out_pc_d      = '0;
            out_a_d       = '0;
            out_b_d       = '0;
            out_imm_d     = '0;
        end
    end

    // Slot payload is only meaningful while busy, so only the busy bits
    // and the issue registers are reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q        <= '0;
            out_op_q      <= '0;
            out_rob_tag_q <= '0;
            out_pc_q      <= '0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_imm_q     <= '0;
        end else begin
            busy_q        <= busy_d;
            op_q          <= op_d;
            tag_q         <= tag_d;
            pc_q          <= pc_d;
            imm_q         <= imm_d;
            srcj_q        <= srcj_d;
            srck_q        <= srck_d;
            out_op_q      <= out_op_d;
            out_rob_tag_q <= out_rob_tag_d;
            out_pc_q      <= out_pc_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_imm_q     <= out_imm_d;
        end
    end

    assign bus.full        = full_w;
    assign bus.out_op      = out_op_q;
    assign bus.out_rob_tag = out_rob_tag_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_a       = out_a_q;
    assign bus.out_b       = out_b_q;
    assign bus.out_imm     = out_imm_q;

endmodule
